// File: rtl/rotx_decrypt_core_if.sv
// ---------------------------------------------------------------------------
// rotx_decrypt_core_if
// Handshake and data bundle for the rotate-xor decrypt core.
//   abort      : producer -> core, synchronous clear of the current job
//   in_valid   : producer -> core, ciphertext/key presented
//   in_ready   : core -> producer, core is idle and can take a job
//   key        : producer -> core, 256-bit secret key
//   cipher_in  : producer -> core, 128-bit ciphertext
//   out_valid  : core -> consumer, plaintext available
//   out_ready  : consumer -> core, plaintext accepted
//   data_out   : core -> consumer, 128-bit plaintext (zero when not valid)
//   busy       : core -> anyone, a job is in flight
// master = the side driving jobs in, slave = the decrypt core.
// ---------------------------------------------------------------------------
interface rotx_decrypt_core_if;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key;
  logic [127:0] cipher_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  modport master (
    output abort, in_valid, key, cipher_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  abort, in_valid, key, cipher_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/rotx_decrypt_core.sv
// ---------------------------------------------------------------------------
// rotx_decrypt_core
// Inverse of the 16-round rotate-xor encrypt core. Each round xors a 32-bit
// slice of the key into the low word and rotates the 128-bit state right by
// 32 bits; a final whitening step xors in the upper half of the key.
// Key and state are wiped after every job (and on abort/reset), and the
// state register only reaches data_out once the plaintext is complete.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rotx_decrypt_core_if.slave (handshakes, key, data, abort, busy)
// ---------------------------------------------------------------------------
module rotx_decrypt_core #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 8
) (
  input logic              clk,
  input logic              rst,
  rotx_decrypt_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  fsm_e             fsmQ,   fsmD;
  logic [255:0]     keyQ,   keyD;
  logic [127:0]     stateQ, stateD;
  logic [IDX_W-1:0] idxQ,   idxD;

  logic [31:0]      roundKey;
  logic [127:0]     roundT;

  // Round key for the current index is key bits [idx+31:idx]; shifting the
  // whole key down by idx and keeping the low word selects exactly that
  // slice. The xor lands only on the low 32 bits of the state.
  always_comb begin
    roundKey = 32'(keyQ >> idxQ);
    roundT   = stateQ ^ {96'b0, roundKey};
  end

  // State register and datapath registers. Reset wins over everything and
  // returns the core to an all-zero idle condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsmQ   <= IDLE;
      keyQ   <= '0;
      stateQ <= '0;
      idxQ   <= '0;
    end else begin
      fsmQ   <= fsmD;
      keyQ   <= keyD;
      stateQ <= stateD;
      idxQ   <= idxD;
    end
  end

  // Next-state logic. Jobs are only sampled in IDLE, one inverse round runs
  // per cycle in ROUND, FINAL applies the whitening and wipes the key, and
  // DONE holds the plaintext until the consumer takes it. Abort overrides
  // every handshake and clears all secret material.
  always_comb begin
    fsmD   = fsmQ;
    keyD   = keyQ;
    stateD = stateQ;
    idxD   = idxQ;

    case (fsmQ)
      IDLE: begin
        if (bus.in_valid) begin
          fsmD   = ROUND;
          keyD   = bus.key;
          stateD = bus.cipher_in;
          idxD   = IDX_W'(1);
        end
      end
      ROUND: begin
        stateD = {roundT[31:0], roundT[127:32]};
        idxD   = idxQ + IDX_W'(1);
        if (idxQ == IDX_W'(ROUNDS)) begin
          fsmD = FINAL;
        end
      end
      FINAL: begin
        stateD = stateQ ^ keyQ[255:128];
        keyD   = '0;
        fsmD   = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          fsmD   = IDLE;
          keyD   = '0;
          stateD = '0;
          idxD   = '0;
        end
      end
      default: begin
        fsmD   = IDLE;
        keyD   = '0;
        stateD = '0;
        idxD   = '0;
      end
    endcase

    if (bus.abort) begin
      fsmD   = IDLE;
      keyD   = '0;
      stateD = '0;
      idxD   = '0;
    end
  end

  // Outputs decode directly from the state register; data_out is gated so
  // partially decrypted state never leaves the core.
  always_comb begin
    bus.in_ready  = (fsmQ == IDLE);
    bus.out_valid = (fsmQ == DONE);
    bus.busy      = (fsmQ != IDLE);
    bus.data_out  = (fsmQ == DONE) ? stateQ : 128'd0;
  end

endmodule

// File: tb/tb_rotx_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_rotx_decrypt_core
// Directed and round-trip checks for the rotate-xor decrypt core: reset
// state, a table of hand-computed vectors, random encrypt/decrypt pairs,
// output backpressure, abort mid-job, reset in DONE and combined
// reset/abort/valid in IDLE.
// ---------------------------------------------------------------------------
module tb_rotx_decrypt_core;

  localparam int ROUNDS = 16;

  logic clk = 1'b0;
  logic rst;

  rotx_decrypt_core_if bus();

  rotx_decrypt_core #(
    .ROUNDS(ROUNDS),
    .IDX_W (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [255:0] key;
    logic [127:0] cipher;
    logic [127:0] expected;
  } vec_t;

  vec_t vecs[6];

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Forward (encrypt) transform, used to build ciphertexts for round trips.
  function automatic logic [127:0] encryptModel(input logic [255:0] k,
                                                input logic [127:0] p);
    logic [127:0] s;
    logic [255:0] sh;
    s = p ^ k[255:128];
    for (int i = ROUNDS; i >= 1; i--) begin
      sh = k >> i;
      s  = {s[95:0], s[127:96]} ^ {96'b0, sh[31:0]};
    end
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r = {r[223:0], $urandom()};
    end
    return r;
  endfunction

  // Present one job at a negedge and return at the negedge after the
  // accepting edge with in_valid dropped.
  task automatic applyStimulus(input logic [255:0] k, input logic [127:0] c);
    checkOutput("ready before accept", 256'(bus.in_ready), 256'd1);
    bus.in_valid  = 1'b1;
    bus.key       = k;
    bus.cipher_in = c;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  // Count edges until out_valid, checking in_ready/busy over the window.
  task automatic waitResult(output int n, output logic windowOk);
    n = 0;
    windowOk = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) windowOk = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  // Full job with out_ready held high.
  task automatic runJob(input string name, input logic [255:0] k,
                        input logic [127:0] c, input logic [127:0] expected);
    int   n;
    logic ok;
    applyStimulus(k, c);
    waitResult(n, ok);
    checkOutput({name, " latency"}, 256'(n), 256'd17);
    checkOutput({name, " data"}, 256'(bus.data_out), 256'(expected));
    checkOutput({name, " busy window"}, 256'(ok), 256'd1);
    @(negedge clk);
    checkOutput({name, " release"},
                256'({bus.in_ready, bus.out_valid, bus.busy, bus.data_out}),
                256'({1'b1, 1'b0, 1'b0, 128'd0}));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] k;
    logic [127:0] p, c;
    int           n;
    logic         ok;
    int           seen;

    vecs[0] = '{256'd0, 128'h0123456789ABCDEF_FEDCBA9876543210,
                128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[1] = '{{128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 128'd0}, 128'd0,
                128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5};
    vecs[2] = '{{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd0},
                128'h0123456789ABCDEF_FEDCBA9876543210,
                128'hFEDCBA9876543210_0123456789ABCDEF};
    vecs[3] = '{{128'h00000000_11111111_22222222_33333333, 128'd0},
                128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0,
                128'h0F0F0F0F_E1E1E1E1_3016745A_A98FEDC3};
    vecs[4] = '{256'h2, 128'd0, 128'h1};
    vecs[5] = '{{128'd0, 128'hFFFFFFFF_FFFFFFFF_FFFF0000_00000000},
                128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF,
                128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF};

    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.key       = '0;
    bus.cipher_in = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("reset outputs",
                256'({bus.in_ready, bus.out_valid, bus.busy, bus.data_out}),
                256'({1'b1, 1'b0, 1'b0, 128'd0}));
    checkOutput("reset keyQ", dut.keyQ, 256'd0);
    checkOutput("reset stateQ/idx", 256'({dut.stateQ, dut.idxQ}), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runJob($sformatf("vec%0d", i), vecs[i].key, vecs[i].cipher, vecs[i].expected);
    end

    for (int i = 0; i < 200; i++) begin
      k = rand256();
      p = 128'(rand256());
      c = encryptModel(k, p);
      runJob("roundtrip", k, c, p);
    end

    // Backpressure: hold DONE for 10 cycles while poking in_valid.
    k = rand256();
    p = 128'(rand256());
    c = encryptModel(k, p);
    bus.out_ready = 1'b0;
    applyStimulus(k, c);
    waitResult(n, ok);
    checkOutput("bp latency", 256'(n), 256'd17);
    checkOutput("bp key wiped", dut.keyQ, 256'd0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = (i % 2 == 0);
      bus.key       = ~k;
      bus.cipher_in = ~c;
      @(negedge clk);
      checkOutput("bp hold", 256'({bus.out_valid, bus.data_out}), 256'({1'b1, p}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release",
                256'({bus.in_ready, bus.out_valid, bus.busy, bus.data_out}),
                256'({1'b1, 1'b0, 1'b0, 128'd0}));
    checkOutput("bp cleared", 256'({dut.stateQ, dut.idxQ}), 256'd0);

    // Abort in the middle of the rounds.
    k = rand256();
    p = 128'(rand256());
    c = encryptModel(k, p);
    applyStimulus(k, c);
    repeat (6) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort outputs",
                256'({bus.in_ready, bus.out_valid, bus.busy, bus.data_out}),
                256'({1'b1, 1'b0, 1'b0, 128'd0}));
    checkOutput("abort keyQ", dut.keyQ, 256'd0);
    checkOutput("abort stateQ/idx", 256'({dut.stateQ, dut.idxQ}), 256'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checkOutput("abort no result", 256'(seen), 256'd0);
    k = rand256();
    p = 128'(rand256());
    runJob("after abort", k, encryptModel(k, p), p);

    // Reset while holding a result in DONE.
    k = rand256();
    p = 128'(rand256());
    bus.out_ready = 1'b0;
    applyStimulus(k, encryptModel(k, p));
    waitResult(n, ok);
    checkOutput("rst-done data", 256'(bus.data_out), 256'(p));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("rst-done outputs",
                256'({bus.in_ready, bus.out_valid, bus.busy, bus.data_out}),
                256'({1'b1, 1'b0, 1'b0, 128'd0}));

    // rst + abort + in_valid together, then abort + in_valid alone.
    rst           = 1'b1;
    bus.abort     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.key       = rand256();
    bus.cipher_in = 128'(rand256());
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst+abort+valid",
                256'({bus.busy, dut.keyQ[31:0], dut.idxQ}), 256'd0);
    @(negedge clk);
    checkOutput("abort+valid", 256'({bus.busy, dut.keyQ[31:0], dut.idxQ}), 256'd0);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle after abort", 256'({bus.in_ready, bus.busy}), 256'({1'b1, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotx_decrypt_core.md
Name: rotx_decrypt_core

Overview:
- Decryption counterpart to the team's 16-round rotate-xor encrypt core; recovers the 128-bit plaintext from a ciphertext and a 256-bit key.
- Sits on the receive side of the crypto datapath and uses valid/ready handshakes on both input and output.
- Unlike the encrypt core, it zeroizes key and state after every operation. It never drives intermediate state onto data_out.

Parameters:
- ROUNDS, 16, number of rounds. Must match the encrypt core and satisfy ROUNDS+31 <= 255.
- IDX_W, 8, width of the round index counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- abort  in  1  synchronous clear of any operation in progress.
- in_valid  in  1  ciphertext/key presented.
- in_ready  out  1  core can accept a job (IDLE only).
- key  in  256  secret key, sampled only on input handshake.
- cipher_in  in  128  ciphertext, sampled only on input handshake.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- data_out  out  128  plaintext; 0 whenever out_valid=0.
- busy  out  1  high in ROUND, FINAL and DONE.

Behaviour:
- Forward transform being inverted, with K = key and i indexing K[i+31:i]:
  - s = P ^ K[255:128]
  - for i = ROUNDS down to 1: s = {s[95:0], s[127:96]} ^ {96'b0, K[i+31:i]}
  - C = s
- Inverse computed here:
  - s = C
  - for i = 1 to ROUNDS: s = t[31:0],t[127:32] rotated, i.e. s = {t[31:0], t[127:32]} where t = s ^ {96'b0, K[i+31:i]}
  - P = s ^ K[255:128]
- One round per cycle. All arithmetic is bitwise only; no carries.
- States:
  - IDLE: in_ready=1.
  - ROUND: one inverse round per cycle.
  - FINAL: whitening with K[255:128].
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> ROUND on in_valid & in_ready. Latch key into key_q, state_q = cipher_in, idx = 1.
  - ROUND: apply round idx, idx++. When idx == ROUNDS, the round is applied and the next state is FINAL.
  - FINAL -> DONE: state_q <= state_q ^ key_q[255:128]; key_q <= 0.
  - DONE: hold data_out stable while out_valid & !out_ready. On out_ready, go to IDLE and clear state_q and idx to 0.
- Latency: out_valid rises ROUNDS+1 = 17 rising edges after the accepting edge. With out_ready held high, in_ready reasserts on the 18th edge. Throughput is one job per 19 cycles minimum.
- in_valid while not IDLE: ignored, no sampling. Inputs are never re-sampled mid-operation.
- Outputs:
  - data_out = state_q only in DONE, else 128'd0.
  - busy = (state != IDLE).
- Reset values: in_ready=1 (state IDLE after reset), out_valid=0, data_out=0, busy=0. key_q, state_q and idx are all 0.
- rst or abort at any cycle, including mid-ROUND or in DONE with out_valid high:
  - next state IDLE, key_q/state_q/idx cleared, out_valid drops next cycle, no result delivered.
  - rst has priority over abort; both have priority over handshakes.
- abort in IDLE coincident with in_valid: job is not accepted.
- Key zeroization is guaranteed no later than the cycle out_valid first rises.

Test Plan:
- Zero key: key=0, cipher_in=128'h0123456789ABCDEF_FEDCBA9876543210 -> data_out equals cipher_in (16 rotations = identity), out_valid 17 edges after accept.
- Whitening only: key={128'hA5A5..A5, 128'h0}, cipher_in=0 -> data_out=128'hA5A5..A5.
- Round trip: 200 random key/plaintext pairs. Encrypt with the forward model, feed C -> data_out == P every time; in_ready low for exactly the busy window.
- Backpressure: out_ready=0 for 10 cycles in DONE -> data_out and out_valid stable; in_valid pulses ignored; accept completes on out_ready=1, then data_out=0 next cycle.
- Abort at round 8 -> out_valid never asserts, in_ready=1 next cycle, internal key_q=0. A new job afterwards decrypts correctly.
- rst asserted in DONE -> out_valid=0, data_out=0, in_ready=1 on next edge. rst+abort+in_valid simultaneously -> no job accepted.
